// File: rtl/dma_burst_sched.sv
// dma_burst_sched: splits one DMA descriptor into 4 KB-safe AXI INCR read bursts and replays
//   each accepted read burst as an equal-length write burst taken from an internal queue.
// Latency: first read request the cycle after descriptor accept; done pulses one cycle after DRAIN.
// Backpressure: reads stall while QDEPTH reads are ahead of writes; valids hold until handshake.
// Ports: desc_* descriptor handshake (desc_ready only in IDLE); rd_req_* / wr_req_* burst request
//   channels; axi_pend_txn / axi_err AXI status; busy / done / err sequencing status.
// Option: define DMA_BURST_STATS_EN to add rd_bursts / wr_bursts handshake counters.
module dma_burst_sched #(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 64,
    parameter int MAX_BEATS  = 16,
    parameter int QDEPTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ADDR_W-1:0]     desc_src,
    input  logic [ADDR_W-1:0]     desc_dst,
    input  logic [31:0]           desc_bytes,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [ADDR_W-1:0]     rd_req_addr,
    output logic [7:0]            rd_req_alen,
    output logic [2:0]            rd_req_size,
    output logic [DATA_BYTES-1:0] rd_req_strb,
    output logic                  wr_req_valid,
    input  logic                  wr_req_ready,
    output logic [ADDR_W-1:0]     wr_req_addr,
    output logic [7:0]            wr_req_alen,
    output logic [2:0]            wr_req_size,
    output logic [DATA_BYTES-1:0] wr_req_strb,
    input  logic                  axi_pend_txn,
    input  logic                  axi_err,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef DMA_BURST_STATS_EN
    ,
    output logic [15:0]           rd_bursts,
    output logic [15:0]           wr_bursts
`endif
);
    localparam int BSH = $clog2(DATA_BYTES);
    localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW  = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state;

    logic [ADDR_W-1:0]     src;       // next read address
    logic [11:0]           rdst;      // destination page offset matching the read position
    logic [ADDR_W-1:0]     dst;       // next write address
    logic [31:0]           rem;       // read beats not yet requested
    logic [BSH-1:0]        tail;      // valid bytes in the final beat, 0 = full beat
    logic [7:0]            q_alen [QDEPTH];
    logic [DATA_BYTES-1:0] q_strb [QDEPTH];
    logic [PW-1:0]         q_rd, q_wr;
    logic [CW-1:0]         q_cnt;
    logic                  rd_pend, wr_pend;  // request shown last cycle but not yet accepted
    logic [31:0]           beats, src_room, dst_room;
    logic                  q_full, q_empty, rd_hs, wr_hs, push, pop;

    // Beats left before each side's next 4 KB page boundary.
    assign src_room = 32'((13'd4096 - {1'b0, src[11:0]}) >> BSH);
    assign dst_room = 32'((13'd4096 - {1'b0, rdst}) >> BSH);

    always_comb begin
        beats = rem;
        if (beats > 32'(MAX_BEATS)) beats = 32'(MAX_BEATS);
        if (beats > src_room)       beats = src_room;
        if (beats > dst_room)       beats = dst_room;
    end

    assign q_full  = (q_cnt == CW'(QDEPTH));
    assign q_empty = (q_cnt == '0);

    // A request shown while not aborted stays up through rd_pend/wr_pend even after
    // the FSM has left RUN, so an abort never withdraws an asserted valid.
    assign rd_req_valid = rd_pend || (state == S_RUN && rem != '0 && !q_full);
    assign wr_req_valid = wr_pend || (state == S_RUN && !q_empty);

    assign rd_req_addr = src;
    assign rd_req_alen = beats[7:0] - 8'd1;
    assign rd_req_size = 3'(BSH);
    assign rd_req_strb = (beats == rem && tail != '0) ? ~({DATA_BYTES{1'b1}} << tail)
                                                      : {DATA_BYTES{1'b1}};
    assign wr_req_addr = dst;
    assign wr_req_alen = q_alen[q_rd];
    assign wr_req_size = 3'(BSH);
    assign wr_req_strb = q_strb[q_rd];

    assign rd_hs = rd_req_valid && rd_req_ready;
    assign wr_hs = wr_req_valid && wr_req_ready;
    // Handshakes completing after an abort only retire the held request.
    assign push  = rd_hs && state == S_RUN;
    assign pop   = wr_hs && state == S_RUN;

    assign desc_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (push) begin
            q_alen[q_wr] <= rd_req_alen;
            q_strb[q_wr] <= rd_req_strb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            src     <= '0;
            rdst    <= '0;
            dst     <= '0;
            rem     <= '0;
            tail    <= '0;
            q_rd    <= '0;
            q_wr    <= '0;
            q_cnt   <= '0;
            rd_pend <= 1'b0;
            wr_pend <= 1'b0;
            err     <= 1'b0;
        end else begin
            rd_pend <= rd_req_valid && !rd_req_ready;
            wr_pend <= wr_req_valid && !wr_req_ready;
            if (push) begin
                q_wr <= (q_wr == PW'(QDEPTH - 1)) ? '0 : q_wr + PW'(1);
                src  <= src + (ADDR_W'(beats) << BSH);
                rdst <= rdst + 12'(beats << BSH);
                rem  <= rem - beats;
            end
            if (pop) begin
                q_rd <= (q_rd == PW'(QDEPTH - 1)) ? '0 : q_rd + PW'(1);
                dst  <= dst + ((ADDR_W'(wr_req_alen) + ADDR_W'(1)) << BSH);
            end
            q_cnt <= q_cnt + CW'(push) - CW'(pop);
            if (busy && axi_err) err <= 1'b1;

            case (state)
                S_IDLE: if (desc_valid) begin
                    state <= S_RUN;
                    src   <= desc_src;
                    rdst  <= desc_dst[11:0];
                    dst   <= desc_dst;
                    rem   <= (desc_bytes >> BSH) + 32'(desc_bytes[BSH-1:0] != '0);
                    tail  <= desc_bytes[BSH-1:0];
                    q_rd  <= '0;
                    q_wr  <= '0;
                    q_cnt <= '0;
                    err   <= 1'b0;
                end
                S_RUN: begin
                    if (axi_err) begin
                        state <= S_DRAIN;
                        q_cnt <= '0;          // queued writes are discarded
                    end else if (rem == '0 && q_empty && !wr_req_valid) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: if (!rd_req_valid && !wr_req_valid && !axi_pend_txn) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DMA_BURST_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && desc_valid)) begin
            rd_bursts <= '0;
            wr_bursts <= '0;
        end else begin
            if (rd_hs && rd_bursts != 16'hFFFF) rd_bursts <= rd_bursts + 16'd1;
            if (wr_hs && wr_bursts != 16'hFFFF) wr_bursts <= wr_bursts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_burst_sched.sv
// tb_dma_burst_sched: randomized and directed stimulus for dma_burst_sched, checked against an
//   in-bench burst-list model (expected read/write bursts per descriptor) every cycle.
// Ports: drives descriptor, ready, AXI status; observes all request channels and status.
module tb_dma_burst_sched;
    localparam int QDEPTH = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  alen;
        logic [63:0] strb;
    } burst_t;

    logic        clk, rst;
    logic        desc_valid, desc_ready;
    logic [31:0] desc_src, desc_dst, desc_bytes;
    logic        rd_req_valid, rd_req_ready, wr_req_valid, wr_req_ready;
    logic [31:0] rd_req_addr, wr_req_addr;
    logic [7:0]  rd_req_alen, wr_req_alen;
    logic [2:0]  rd_req_size, wr_req_size;
    logic [63:0] rd_req_strb, wr_req_strb;
    logic        axi_pend_txn, axi_err, busy, done, err;

    dma_burst_sched dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_src(desc_src), .desc_dst(desc_dst), .desc_bytes(desc_bytes),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_req_alen(rd_req_alen), .rd_req_size(rd_req_size), .rd_req_strb(rd_req_strb),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
        .wr_req_alen(wr_req_alen), .wr_req_size(wr_req_size), .wr_req_strb(wr_req_strb),
        .axi_pend_txn(axi_pend_txn), .axi_err(axi_err),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int rd_pct = 100, wr_pct = 100;
    int rd_hs_cnt = 0, wr_hs_cnt = 0, done_cnt = 0;
    bit chk_en = 0, abort_mode = 0;
    burst_t exp_rd[$], exp_wr[$];
    logic [7:0]  last_rd_alen;
    logic [63:0] last_rd_strb;
    logic [2:0]  last_rd_size;
    bit prev_rd_pend = 0, prev_wr_pend = 0;
    logic [31:0] prev_rd_addr, prev_wr_addr;
    logic [7:0]  prev_rd_alen, prev_wr_alen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endtask

    // Ready generation: independent random acceptance per channel.
    initial begin
        rd_req_ready = 1'b0;
        wr_req_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rd_req_ready = (int'($urandom_range(0, 99)) < rd_pct);
            wr_req_ready = (int'($urandom_range(0, 99)) < wr_pct);
        end
    end

    // Compare process: every request shown must be the next expected burst of its channel.
    always @(negedge clk) begin
        if (!chk_en) begin
            prev_rd_pend = 0;
            prev_wr_pend = 0;
        end else begin
            chk("desc_ready_vs_busy", desc_ready, !busy);
            if (prev_rd_pend) begin
                chk("rd_hold_valid", rd_req_valid, 1);
                chk("rd_hold_addr", rd_req_addr, prev_rd_addr);
                chk("rd_hold_alen", rd_req_alen, prev_rd_alen);
            end
            if (prev_wr_pend) begin
                chk("wr_hold_valid", wr_req_valid, 1);
                chk("wr_hold_addr", wr_req_addr, prev_wr_addr);
                chk("wr_hold_alen", wr_req_alen, prev_wr_alen);
            end
            if (abort_mode) begin
                chk("rd_new_after_abort", rd_req_valid && !prev_rd_pend, 0);
                chk("wr_new_after_abort", wr_req_valid && !prev_wr_pend, 0);
            end
            if (wr_req_valid) begin
                chk("wr_without_rd", wr_hs_cnt < rd_hs_cnt, 1);
                if (exp_wr.size() == 0) chk("wr_unexpected", wr_req_valid, 0);
                else begin
                    chk("wr_addr", wr_req_addr, exp_wr[0].addr);
                    chk("wr_alen", wr_req_alen, exp_wr[0].alen);
                    chk("wr_strb", wr_req_strb, exp_wr[0].strb);
                    chk("wr_size", wr_req_size, 6);
                    if (wr_req_ready) begin
                        void'(exp_wr.pop_front());
                        wr_hs_cnt++;
                    end
                end
            end
            if (rd_req_valid) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", rd_req_valid, 0);
                else begin
                    chk("rd_addr", rd_req_addr, exp_rd[0].addr);
                    chk("rd_alen", rd_req_alen, exp_rd[0].alen);
                    chk("rd_strb", rd_req_strb, exp_rd[0].strb);
                    chk("rd_size", rd_req_size, 6);
                    if (rd_req_ready) begin
                        void'(exp_rd.pop_front());
                        rd_hs_cnt++;
                        last_rd_alen = rd_req_alen;
                        last_rd_strb = rd_req_strb;
                        last_rd_size = rd_req_size;
                    end
                end
            end
            if (!abort_mode) chk("queue_bound", (rd_hs_cnt - wr_hs_cnt) <= QDEPTH, 1);
            if (done) done_cnt++;
            prev_rd_pend = rd_req_valid && !rd_req_ready;
            prev_wr_pend = wr_req_valid && !wr_req_ready;
            prev_rd_addr = rd_req_addr;
            prev_rd_alen = rd_req_alen;
            prev_wr_addr = wr_req_addr;
            prev_wr_alen = wr_req_alen;
        end
    end

    // Model: build the expected burst lists, then hand the descriptor over.
    task automatic start_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] nbytes);
        logic [63:0] rem, b, room, tail, sa, da;
        burst_t e;
        rem  = (64'(nbytes) + 64'd63) / 64;
        tail = 64'(nbytes) % 64;
        sa   = 64'(s);
        da   = 64'(d);
        while (rem > 0) begin
            b = (rem < 16) ? rem : 64'd16;
            room = (64'd4096 - sa % 4096) / 64;
            if (room < b) b = room;
            room = (64'd4096 - da % 4096) / 64;
            if (room < b) b = room;
            e.alen = 8'(b - 1);
            e.strb = (b == rem && tail != 0) ? ((64'd1 << tail) - 64'd1) : 64'hFFFF_FFFF_FFFF_FFFF;
            e.addr = 32'(sa);
            exp_rd.push_back(e);
            e.addr = 32'(da);
            exp_wr.push_back(e);
            sa  = sa + b * 64;
            da  = da + b * 64;
            rem = rem - b;
        end
        rd_hs_cnt  = 0;
        wr_hs_cnt  = 0;
        done_cnt   = 0;
        desc_src   = s;
        desc_dst   = d;
        desc_bytes = nbytes;
        desc_valid = 1'b1;
        @(negedge clk);
        chk("desc_ready_at_start", desc_ready, 1);
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_done_timeout"}, n < budget, 1);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_done_once"}, done_cnt, 1);
        chk({name, "_idle_after"}, busy, 0);
    endtask

    initial begin
        int at;
        logic [31:0] s, d, b;
        rst = 1'b1;
        desc_valid = 1'b0;
        desc_src = '0;
        desc_dst = '0;
        desc_bytes = '0;
        axi_pend_txn = 1'b0;
        axi_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_desc_ready", desc_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_rd_valid", rd_req_valid, 0);
        chk("reset_wr_valid", wr_req_valid, 0);
        rst = 1'b0;
        chk_en = 1;

        // T1: two full 16-beat bursts each way.
        start_desc(32'h1000, 32'h2000, 2048);
        wait_done("t1", 500);
        chk("t1_rd_count", rd_hs_cnt, 2);
        chk("t1_wr_count", wr_hs_cnt, 2);
        chk("t1_alen", last_rd_alen, 15);
        chk("t1_strb", last_rd_strb, 64'hFFFF_FFFF_FFFF_FFFF);

        // T2: 4 KB split of the source.
        start_desc(32'h0F80, 32'h3000, 256);
        chk("t2_model_rd0_alen", exp_rd[0].alen, 1);
        chk("t2_model_rd1_addr", exp_rd[1].addr, 32'h1000);
        chk("t2_model_wr0_addr", exp_wr[0].addr, 32'h3000);
        chk("t2_model_wr1_addr", exp_wr[1].addr, 32'h3080);
        wait_done("t2", 500);
        chk("t2_rd_count", rd_hs_cnt, 2);

        // T3: partial final beat.
        start_desc(32'h5000, 32'h6000, 100);
        wait_done("t3", 500);
        chk("t3_rd_count", rd_hs_cnt, 1);
        chk("t3_alen", last_rd_alen, 1);
        chk("t3_strb", last_rd_strb, 64'h0000_000F_FFFF_FFFF);
        chk("t3_size", last_rd_size, 6);

        // T4: writes blocked, reads stop at queue depth.
        rd_pct = 100;
        wr_pct = 0;
        start_desc(32'h0, 32'h10000, 16384);
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("t4_rd_ahead", rd_hs_cnt, QDEPTH);
        chk("t4_rd_stalled", rd_req_valid, 0);
        @(posedge clk);
        #1;
        wr_pct = 100;
        wait_done("t4", 2000);
        chk("t4_rd_count", rd_hs_cnt, 16);
        chk("t4_wr_count", wr_hs_cnt, 16);

        // T5: abort while a read request is held.
        rd_pct = 0;
        wr_pct = 100;
        start_desc(32'h4000, 32'h8000, 4096);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_rd_pending", rd_req_valid, 1);
        axi_err = 1'b1;
        axi_pend_txn = 1'b1;
        abort_mode = 1;
        @(posedge clk);
        #1;
        axi_err = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_rd_held", rd_req_valid, 1);
        chk("t5_err", err, 1);
        chk("t5_busy", busy, 1);
        rd_pct = 100;
        repeat (12) @(posedge clk);
        #1;
        chk("t5_one_rd", rd_hs_cnt, 1);
        chk("t5_no_wr", wr_hs_cnt, 0);
        chk("t5_rd_low", rd_req_valid, 0);
        chk("t5_no_done_yet", done_cnt, 0);
        axi_pend_txn = 1'b0;
        wait_done("t5", 50);
        chk("t5_err_sticky", err, 1);
        abort_mode = 0;
        exp_rd.delete();
        exp_wr.delete();

        // T6: zero-length descriptor, then reset mid-transfer.
        start_desc(32'h7000, 32'h9000, 0);
        chk("t6_err_cleared", err, 0);
        at = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (done && at == 0) at = i;
        end
        chk("t6_done_delay", at, 3);
        chk("t6_done_once", done_cnt, 1);
        @(posedge clk);
        #1;
        rd_pct = 50;
        wr_pct = 50;
        start_desc(32'h20000, 32'h40000, 8192);
        repeat (10) @(posedge clk);
        #1;
        chk_en = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rd_valid", rd_req_valid, 0);
        chk("t6_rst_wr_valid", wr_req_valid, 0);
        chk("t6_rst_desc_ready", desc_ready, 1);
        rst = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        chk_en = 1;

        // Randomized descriptors and ready patterns.
        for (int n = 0; n < 30; n++) begin
            rd_pct = $urandom_range(30, 100);
            wr_pct = $urandom_range(30, 100);
            s = 32'($urandom_range(0, 32'h000F_FFFF)) & 32'hFFFF_FFC0;
            d = 32'($urandom_range(0, 32'h000F_FFFF)) & 32'hFFFF_FFC0;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20000))
                                            : 32'($urandom_range(0, 2000));
            start_desc(s, d, b);
            wait_done("rnd", 5000);
            chk("rnd_rd_all_issued", exp_rd.size(), 0);
            chk("rnd_wr_all_issued", exp_wr.size(), 0);
            chk("rnd_err", err, 0);
            exp_rd.delete();
            exp_wr.delete();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
